// File: rtl/io_bridge_fx.sv
// ---------------------------------------------------------------------------
// io_bridge_fx
//
// Purpose:
//   Buffered, flow-controlled bridge between a core_fx-class processor I/O
//   port and a set of valid/ready stream channels. Each input channel has a
//   one-word hold register. Each output channel has a FIFO of FDEPTH words.
//   The core is stalled when it reads an empty input or writes a full output.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   req_in, addr_in      core read request and input channel select
//   io_in                read data to core (0 unless a valid read is presented)
//   out_en, addr_out     core write request and output channel select
//   data_out             write data from core
//   stall                core must freeze and hold its I/O request
//   in_data/valid/ready  input stream channels (channel i at [i*NUBITS +: NUBITS])
//   out_data/valid/ready output stream channels (FIFO head of channel c)
//   addr_err             sticky flag: an out-of-range channel was accessed
// ---------------------------------------------------------------------------
module io_bridge_fx #(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          req_in,
    input  logic [((NUIOIN > 1) ? $clog2(NUIOIN) : 1)-1:0] addr_in,
    output logic [NUBITS-1:0]                             io_in,
    input  logic                                          out_en,
    input  logic [((NUIOOU > 1) ? $clog2(NUIOOU) : 1)-1:0] addr_out,
    input  logic [NUBITS-1:0]                             data_out,
    output logic                                          stall,
    input  logic [NUIOIN*NUBITS-1:0]                      in_data,
    input  logic [NUIOIN-1:0]                             in_valid,
    output logic [NUIOIN-1:0]                             in_ready,
    output logic [NUIOOU*NUBITS-1:0]                      out_data,
    output logic [NUIOOU-1:0]                             out_valid,
    input  logic [NUIOOU-1:0]                             out_ready,
    output logic                                          addr_err
);

    localparam int IW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int OW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;

    // Input hold registers
    logic [NUBITS-1:0] hold_data_q [NUIOIN];
    logic [NUBITS-1:0] hold_data_d [NUIOIN];
    logic [NUIOIN-1:0] hold_valid_q, hold_valid_d;

    // Output FIFOs
    logic [NUBITS-1:0] mem_q [NUIOOU][FDEPTH];
    logic [NUBITS-1:0] mem_d [NUIOOU][FDEPTH];
    logic [PW-1:0]     wr_ptr_q [NUIOOU];
    logic [PW-1:0]     wr_ptr_d [NUIOOU];
    logic [PW-1:0]     rd_ptr_q [NUIOOU];
    logic [PW-1:0]     rd_ptr_d [NUIOOU];
    logic [CW-1:0]     count_q  [NUIOOU];
    logic [CW-1:0]     count_d  [NUIOOU];

    logic addr_err_q, addr_err_d;

    // Decoded request/handshake terms
    logic [NUIOIN-1:0] rd_sel, rd_fire, load;
    logic [NUIOOU-1:0] wr_sel, wr_fire, full, pop;
    logic              in_stall, out_stall;

    // Address decode and flow control. An out-of-range address selects no
    // channel, so it can never stall. Each direction only commits when the
    // other is not stalling, because the core replays both requests while
    // frozen; committing one side early would duplicate or lose a word.
    // The same gating keeps a stalled read from freeing its hold register.
    always_comb begin
        rd_sel = '0;
        wr_sel = '0;
        full   = '0;
        pop    = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            rd_sel[i] = req_in && (addr_in == IW'(i));
        end
        for (int c = 0; c < NUIOOU; c++) begin
            wr_sel[c] = out_en && (addr_out == OW'(c));
            full[c]   = (count_q[c] == CW'(FDEPTH));
            pop[c]    = (count_q[c] != '0) && out_ready[c];
        end
        in_stall  = |(rd_sel & ~hold_valid_q);
        out_stall = |(wr_sel & full);
        stall     = ~rst & (in_stall | out_stall);
        rd_fire   = rd_sel & hold_valid_q & {NUIOIN{~out_stall}};
        wr_fire   = wr_sel & ~full & {NUIOOU{~in_stall}};
        in_ready  = rst ? '0 : (~hold_valid_q | rd_fire);
        load      = in_valid & in_ready;
    end

    // Read data and output stream views of the registered state
    always_comb begin
        io_in     = '0;
        out_data  = '0;
        out_valid = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            if (rd_sel[i] && hold_valid_q[i]) begin
                io_in = hold_data_q[i];
            end
        end
        for (int c = 0; c < NUIOOU; c++) begin
            out_data[c*NUBITS +: NUBITS] = mem_q[c][rd_ptr_q[c]];
            out_valid[c]                 = (count_q[c] != '0);
        end
        addr_err = addr_err_q;
    end

    // Input hold registers: a refill on the same edge as a consume wins,
    // which gives one word per cycle on a continuously read channel.
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        for (int i = 0; i < NUIOIN; i++) begin
            if (load[i]) begin
                hold_data_d[i]  = in_data[i*NUBITS +: NUBITS];
                hold_valid_d[i] = 1'b1;
            end else if (rd_fire[i]) begin
                hold_valid_d[i] = 1'b0;
            end
        end
    end

    // Output FIFO pointers and occupancy. A push is only admitted on the
    // registered count, so a pop on a full FIFO frees the slot for the next
    // cycle rather than the current one.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int c = 0; c < NUIOOU; c++) begin
            if (wr_fire[c]) begin
                mem_d[c][wr_ptr_q[c]] = data_out;
                wr_ptr_d[c]           = wr_ptr_q[c] + PW'(1);
            end
            if (pop[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
            end
            case ({wr_fire[c], pop[c]})
                2'b10:   count_d[c] = count_q[c] + CW'(1);
                2'b01:   count_d[c] = count_q[c] - CW'(1);
                default: count_d[c] = count_q[c];
            endcase
        end
    end

    // Sticky out-of-range detector: a request that decodes to no channel
    always_comb begin
        addr_err_d = addr_err_q | (req_in & ~|rd_sel) | (out_en & ~|wr_sel);
    end

    // Control state with asynchronous reset; reset discards all buffered data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= '0;
            addr_err_q   <= 1'b0;
            for (int i = 0; i < NUIOIN; i++) begin
                hold_data_q[i] <= '0;
            end
            for (int c = 0; c < NUIOOU; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            addr_err_q   <= addr_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage needs no reset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_io_bridge_fx.sv
// ---------------------------------------------------------------------------
// tb_io_bridge_fx
//
// Purpose:
//   Directed bench for io_bridge_fx with 6 input channels, 6 output channels,
//   32-bit data and 4-deep output FIFOs. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_io_bridge_fx;

    localparam int NUBITS = 32;
    localparam int NUIOIN = 6;
    localparam int NUIOOU = 6;
    localparam int FDEPTH = 4;

    logic                     clk;
    logic                     rst;
    logic                     req_in;
    logic [2:0]               addr_in;
    logic [NUBITS-1:0]        io_in;
    logic                     out_en;
    logic [2:0]               addr_out;
    logic [NUBITS-1:0]        data_out;
    logic                     stall;
    logic [NUIOIN*NUBITS-1:0] in_data;
    logic [NUIOIN-1:0]        in_valid;
    logic [NUIOIN-1:0]        in_ready;
    logic [NUIOOU*NUBITS-1:0] out_data;
    logic [NUIOOU-1:0]        out_valid;
    logic [NUIOOU-1:0]        out_ready;
    logic                     addr_err;

    int checks = 0;
    int errors = 0;

    io_bridge_fx #(
        .NUBITS(NUBITS),
        .NUIOIN(NUIOIN),
        .NUIOOU(NUIOOU),
        .FDEPTH(FDEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .addr_in  (addr_in),
        .io_in    (io_in),
        .out_en   (out_en),
        .addr_out (addr_out),
        .data_out (data_out),
        .stall    (stall),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .addr_err (addr_err)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and land just after the last one
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and reports tag/observed/expected on a miss
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Directed sequence
    initial begin
        rst       = 1'b1;
        req_in    = 1'b0;
        addr_in   = '0;
        out_en    = 1'b0;
        addr_out  = '0;
        data_out  = '0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = '0;

        // Reset state
        #3;
        checkOutput("rst_in_ready", 64'(in_ready), 64'h0);
        checkOutput("rst_stall", 64'(stall), 64'h0);
        checkOutput("rst_io_in", 64'(io_in), 64'h0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
        applyStimulus(2);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'h3F);
        checkOutput("post_rst_addr_err", 64'(addr_err), 64'h0);
        checkOutput("post_rst_stall", 64'(stall), 64'h0);

        // Input load then read on channel 2
        $display("[TB] input load/read on channel 2");
        in_valid = 6'b000100;
        in_data[2*NUBITS +: NUBITS] = 32'h1234;
        applyStimulus(1);
        in_valid = '0;
        #1;
        checkOutput("ch2_in_ready_full", 64'(in_ready), 64'h3B);
        req_in  = 1'b1;
        addr_in = 3'd2;
        #1;
        checkOutput("ch2_io_in", 64'(io_in), 64'h1234);
        checkOutput("ch2_stall", 64'(stall), 64'h0);
        checkOutput("ch2_ready_on_read", 64'(in_ready[2]), 64'h1);
        applyStimulus(1);
        #1;
        checkOutput("ch2_empty_stall", 64'(stall), 64'h1);
        checkOutput("ch2_empty_io_in", 64'(io_in), 64'h0);
        req_in = 1'b0;

        // Back-to-back read with same-edge refill on channel 0
        $display("[TB] full-throughput read on channel 0");
        in_valid = 6'b000001;
        in_data[0 +: NUBITS] = 32'h11;
        applyStimulus(1);
        in_data[0 +: NUBITS] = 32'h22;
        req_in  = 1'b1;
        addr_in = 3'd0;
        #1;
        checkOutput("ch0_first_word", 64'(io_in), 64'h11);
        checkOutput("ch0_refill_ready", 64'(in_ready[0]), 64'h1);
        applyStimulus(1);
        in_valid = '0;
        #1;
        checkOutput("ch0_second_word", 64'(io_in), 64'h22);
        checkOutput("ch0_second_stall", 64'(stall), 64'h0);
        applyStimulus(1);
        req_in = 1'b0;
        #1;
        checkOutput("ch0_drained_ready", 64'(in_ready), 64'h3F);

        // Read stall on empty channel 5 until data arrives
        $display("[TB] read stall on channel 5");
        req_in  = 1'b1;
        addr_in = 3'd5;
        #1;
        checkOutput("ch5_stall_start", 64'(stall), 64'h1);
        checkOutput("ch5_io_in_zero", 64'(io_in), 64'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1);
            checkOutput("ch5_stall_held", 64'(stall), 64'h1);
        end
        in_valid = 6'b100000;
        in_data[5*NUBITS +: NUBITS] = 32'hBEEF;
        #1;
        checkOutput("ch5_stall_arrive_cycle", 64'(stall), 64'h1);
        applyStimulus(1);
        in_valid = '0;
        #1;
        checkOutput("ch5_stall_clear", 64'(stall), 64'h0);
        checkOutput("ch5_io_in", 64'(io_in), 64'hBEEF);
        applyStimulus(1);
        req_in = 1'b0;

        // Fill channel 1 past capacity, then drain in order
        $display("[TB] output FIFO fill/drain on channel 1");
        out_en   = 1'b1;
        addr_out = 3'd1;
        for (int k = 1; k <= 4; k++) begin
            data_out = 32'(k);
            #1;
            checkOutput("ch1_write_no_stall", 64'(stall), 64'h0);
            applyStimulus(1);
        end
        data_out = 32'd5;
        #1;
        checkOutput("ch1_full_stall", 64'(stall), 64'h1);
        checkOutput("ch1_out_valid", 64'(out_valid), 64'h02);
        checkOutput("ch1_head_1", 64'(out_data[1*NUBITS +: NUBITS]), 64'h1);
        applyStimulus(1);
        checkOutput("ch1_full_stall_held", 64'(stall), 64'h1);
        out_ready = 6'b000010;
        #1;
        checkOutput("ch1_pop_cycle_stall", 64'(stall), 64'h1);
        applyStimulus(1);
        checkOutput("ch1_stall_clear", 64'(stall), 64'h0);
        checkOutput("ch1_head_2", 64'(out_data[1*NUBITS +: NUBITS]), 64'h2);
        applyStimulus(1);
        out_en = 1'b0;
        #1;
        checkOutput("ch1_head_3", 64'(out_data[1*NUBITS +: NUBITS]), 64'h3);
        applyStimulus(1);
        checkOutput("ch1_head_4", 64'(out_data[1*NUBITS +: NUBITS]), 64'h4);
        applyStimulus(1);
        checkOutput("ch1_head_5", 64'(out_data[1*NUBITS +: NUBITS]), 64'h5);
        applyStimulus(1);
        checkOutput("ch1_empty", 64'(out_valid), 64'h0);
        out_ready = '0;

        // Push and pop in the same cycle on a full FIFO (channel 3)
        $display("[TB] push+pop on full FIFO, channel 3");
        out_en   = 1'b1;
        addr_out = 3'd3;
        for (int k = 0; k < 4; k++) begin
            data_out = 32'hA0 + 32'(k);
            applyStimulus(1);
        end
        data_out = 32'hA4;
        #1;
        checkOutput("ch3_full_stall", 64'(stall), 64'h1);
        out_ready = 6'b001000;
        #1;
        checkOutput("ch3_push_pop_stall", 64'(stall), 64'h1);
        applyStimulus(1);
        out_ready = '0;
        #1;
        checkOutput("ch3_after_pop_stall", 64'(stall), 64'h0);
        checkOutput("ch3_head_a1", 64'(out_data[3*NUBITS +: NUBITS]), 64'hA1);
        applyStimulus(1);
        data_out = 32'hA5;
        #1;
        checkOutput("ch3_full_again", 64'(stall), 64'h1);
        out_en    = 1'b0;
        out_ready = 6'b001000;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checkOutput("ch3_drain", 64'(out_data[3*NUBITS +: NUBITS]), 64'hA0 + 64'(k));
            applyStimulus(1);
        end
        #1;
        checkOutput("ch3_empty", 64'(out_valid), 64'h0);
        out_ready = '0;

        // Out-of-range accesses
        $display("[TB] out-of-range addresses");
        req_in  = 1'b1;
        addr_in = 3'd7;
        #1;
        checkOutput("oor_rd_io_in", 64'(io_in), 64'h0);
        checkOutput("oor_rd_stall", 64'(stall), 64'h0);
        checkOutput("oor_err_before_edge", 64'(addr_err), 64'h0);
        applyStimulus(1);
        req_in = 1'b0;
        #1;
        checkOutput("oor_err_set", 64'(addr_err), 64'h1);
        out_en   = 1'b1;
        addr_out = 3'd6;
        data_out = 32'h77;
        #1;
        checkOutput("oor_wr_stall", 64'(stall), 64'h0);
        applyStimulus(1);
        out_en = 1'b0;
        #1;
        checkOutput("oor_wr_dropped", 64'(out_valid), 64'h0);
        applyStimulus(3);
        checkOutput("oor_err_sticky", 64'(addr_err), 64'h1);

        // Reset while stalled with a partially full FIFO
        $display("[TB] reset during stall");
        out_en   = 1'b1;
        addr_out = 3'd4;
        data_out = 32'h44;
        applyStimulus(2);
        out_en  = 1'b0;
        req_in  = 1'b1;
        addr_in = 3'd1;
        #1;
        checkOutput("pre_rst_stall", 64'(stall), 64'h1);
        checkOutput("pre_rst_out_valid", 64'(out_valid), 64'h10);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_stall", 64'(stall), 64'h0);
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'h0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'h0);
        checkOutput("mid_rst_addr_err", 64'(addr_err), 64'h0);
        checkOutput("mid_rst_io_in", 64'(io_in), 64'h0);
        req_in = 1'b0;
        applyStimulus(2);
        rst = 1'b0;
        #1;
        checkOutput("end_in_ready", 64'(in_ready), 64'h3F);
        checkOutput("end_out_valid", 64'(out_valid), 64'h0);
        checkOutput("end_stall", 64'(stall), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
